mig_axi_arbiter: RTL and testbench
==================================

# mig_axi_arbiter

Two-port arbiter and sequencer in front of the MIG AXI4 slave port (128-bit data, 32-bit address). It accepts single-line (16-byte) read and write requests from two clients: port 0 for the instruction-side refill and port 1 for the data-side refill/writeback. Round-robin arbitration selects one request at a time, and the selected request is issued as exactly one single-beat AXI4 transaction. The block also holds all constant AXI sideband fields, so clients see only a simple req/done interface.

## Interface
- No parameters; widths fixed by the MIG port (ADDR 32, DATA 128, STRB 16).
- clk  in  1  single clock, shared with MIG clk_axi
- rst  in  1  asynchronous, active-high reset
- reqN (N=0,1)  in  1  request; held high until doneN is sampled
- weN  in  1  1 = write, 0 = read; stable while reqN high
- addrN  in  32  byte address; bits [3:0] ignored, driven as 0 on AXI
- wdataN / wstrbN  in  128 / 16  write data and byte strobes; stable while reqN high
- doneN  out  1  one-cycle completion pulse
- rdataN  out  128  read data; valid in the doneN cycle and held until the next read on that port
- errN  out  1  one-cycle pulse with doneN when RRESP/BRESP is not 2'b00
- busy  out  1  high whenever state is not IDLE
- m_axi_* master port, connected to MIG_BLOCK S_AXI_*:
  - driven: araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  - sampled: arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  - constants: ar/aw burst 2'b01, size 3'b100, len 0, id 0, lock 0, cache 4'b0011, prot 0, qos 0, region 0; wlast 1

## Operation
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- IDLE
  - With no req, stay.
  - Otherwise grant:
    - only one reqN high: grant that port.
    - both high: grant the port opposite to `last`. `last` is a 1-bit register, reset 1, so port 0 wins the first tie.
  - On grant, latch port index, addr (with [3:0] forced to 0), we, wdata and wstrb, and update `last`.
  - Next state: RADDR if read, WRITE if write.
- RADDR: arvalid=1 until arready sampled high, then RDATA.
- RDATA: rready=1. On rvalid, capture rdata and rresp[1]|rresp[0], then DONE.
- WRITE
  - awvalid and wvalid rise together.
  - Each drops independently after its own ready is sampled high; flags aw_ok and w_ok track this.
  - When both handshakes are complete (same or different cycles), go to WRESP.
- WRESP: bready=1. On bvalid, capture bresp error, then DONE.
- DONE: doneN=1 for the granted port, errN per captured response; next state is IDLE.
- Valid signals never drop before their handshake. Payload is constant while valid is high.
- Requests are sampled only in IDLE. A request raised during a transaction waits; it is not lost if held.

## Timing
- Reset (async, immediate) state:
  - state IDLE; `last`=1.
  - all m_axi valid/ready outputs 0; doneN, errN, busy 0.
  - rdataN 0; araddr/awaddr/wdata/wstrb 0.
- Reset mid-transaction: outputs drop at once. No completion is reported; the client reissues.
- Minimum latency, req sampled at edge 0:
  - arvalid is high in the cycle after edge 0.
  - doneN is high in the cycle after the R (or B) handshake edge.
  - With zero-wait ready/valid this gives done at edge 3 for reads and edge 3 for writes.
  - Against MIG_BLOCK timing, done is at edge 4 for both.
- Client protocol:
  - Requester drops reqN at the edge where doneN=1 is sampled, so reqN is low in the following IDLE cycle.
  - The next request may be raised in that IDLE cycle; a new grant occurs one cycle later.
- Minimum issue spacing between back-to-back transactions: DONE→IDLE→issue, i.e. 2 idle cycles.
- No combinational path from any m_axi input to any m_axi output. All outputs are registered or decoded from the state register.

## Test plan
- Single read, port 0:
  - Stimulus: preload mem[0x100]; assert req0, we0=0, addr0=0x0000_010C.
  - Required: araddr=0x100, arlen=0, arsize=3'b100; done0 for one cycle with rdata0 equal to the preload; err0=0; busy back to 0.
- Single write, port 1, strobes:
  - Stimulus: wstrb1=16'h00F0, wdata1=all 0xAA; then read the line back.
  - Required: only bytes 4–7 change; done1 pulses once per transaction.
- Simultaneous requests:
  - Stimulus: req0 and req1 raised in the same cycle, repeated 4 times.
  - Required: grant order 0,1,0,1; no transaction overlap (single arvalid/awvalid outstanding).
- Split write handshake:
  - Stimulus: slave model holds awready low 3 cycles after wready fires.
  - Required: wvalid drops after its handshake, awvalid stays high; WRESP entered only after both; exactly one write to memory.
- Error response:
  - Stimulus: slave returns rresp=2'b10.
  - Required: err0 and done0 pulse together; FSM returns to IDLE.
- Async reset in RDATA:
  - Stimulus: assert rst between arready and rvalid.
  - Required: rready, busy, done0 all 0 immediately; state IDLE after reset release; next request completes normally.

Source files
------------

// File: rtl/mig_axi_arbiter.sv
// Two-port round-robin arbiter that turns single-line client read/write requests
// into single-beat AXI4 transactions on the MIG slave port.
module mig_axi_arbiter (
  input  logic         clk_i,
  input  logic         rst_i,
  // client port 0 (instruction refill)
  input  logic         req0_i,
  input  logic         we0_i,
  input  logic [31:0]  addr0_i,
  input  logic [127:0] wdata0_i,
  input  logic [15:0]  wstrb0_i,
  output logic         done0_o,
  output logic [127:0] rdata0_o,
  output logic         err0_o,
  // client port 1 (data refill / writeback)
  input  logic         req1_i,
  input  logic         we1_i,
  input  logic [31:0]  addr1_i,
  input  logic [127:0] wdata1_i,
  input  logic [15:0]  wstrb1_i,
  output logic         done1_o,
  output logic [127:0] rdata1_o,
  output logic         err1_o,
  output logic         busy_o,
  // AXI4 read address channel
  output logic [31:0]  m_axi_araddr_o,
  output logic         m_axi_arvalid_o,
  input  logic         m_axi_arready_i,
  output logic [1:0]   m_axi_arburst_o,
  output logic [2:0]   m_axi_arsize_o,
  output logic [7:0]   m_axi_arlen_o,
  output logic [3:0]   m_axi_arid_o,
  output logic         m_axi_arlock_o,
  output logic [3:0]   m_axi_arcache_o,
  output logic [2:0]   m_axi_arprot_o,
  output logic [3:0]   m_axi_arqos_o,
  output logic [3:0]   m_axi_arregion_o,
  // AXI4 read data channel
  input  logic [127:0] m_axi_rdata_i,
  input  logic [1:0]   m_axi_rresp_i,
  input  logic         m_axi_rvalid_i,
  output logic         m_axi_rready_o,
  // AXI4 write address channel
  output logic [31:0]  m_axi_awaddr_o,
  output logic         m_axi_awvalid_o,
  input  logic         m_axi_awready_i,
  output logic [1:0]   m_axi_awburst_o,
  output logic [2:0]   m_axi_awsize_o,
  output logic [7:0]   m_axi_awlen_o,
  output logic [3:0]   m_axi_awid_o,
  output logic         m_axi_awlock_o,
  output logic [3:0]   m_axi_awcache_o,
  output logic [2:0]   m_axi_awprot_o,
  output logic [3:0]   m_axi_awqos_o,
  output logic [3:0]   m_axi_awregion_o,
  // AXI4 write data channel
  output logic [127:0] m_axi_wdata_o,
  output logic [15:0]  m_axi_wstrb_o,
  output logic         m_axi_wlast_o,
  output logic         m_axi_wvalid_o,
  input  logic         m_axi_wready_i,
  // AXI4 write response channel
  input  logic [1:0]   m_axi_bresp_i,
  input  logic         m_axi_bvalid_i,
  output logic         m_axi_bready_o
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic           port_q, port_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [15:0]    wstrb_q, wstrb_d;
  logic           awOk_q, awOk_d;
  logic           wOk_q, wOk_d;
  logic           err_q, err_d;
  logic [127:0]   rdata0_q, rdata0_d;
  logic [127:0]   rdata1_q, rdata1_d;
  logic           grant;
  logic           awDone;
  logic           wDone;

  // Low address bits are always forced to zero on the bus.
  logic unused_addr_low;
  assign unused_addr_low = ^{addr0_i[3:0], addr1_i[3:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awOk_q   <= 1'b0;
      wOk_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      awOk_q   <= awOk_d;
      wOk_q    <= wOk_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    awOk_d   = awOk_q;
    wOk_d    = wOk_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant    = 1'b0;
    awDone   = awOk_q | m_axi_awready_i;
    wDone    = wOk_q | m_axi_wready_i;

    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie the port that did not win last time is granted.
          if (req0_i && req1_i) grant = ~last_q;
          else                  grant = req1_i;
          port_d = grant;
          last_d = grant;
          awOk_d = 1'b0;
          wOk_d  = 1'b0;
          err_d  = 1'b0;
          if (grant) begin
            addr_d  = {addr1_i[31:4], 4'h0};
            we_d    = we1_i;
            wdata_d = wdata1_i;
            wstrb_d = wstrb1_i;
            state_d = we1_i ? WRITE : RADDR;
          end else begin
            addr_d  = {addr0_i[31:4], 4'h0};
            we_d    = we0_i;
            wdata_d = wdata0_i;
            wstrb_d = wstrb0_i;
            state_d = we0_i ? WRITE : RADDR;
          end
        end
      end
      RADDR: begin
        if (m_axi_arready_i) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid_i) begin
          err_d = |m_axi_rresp_i;
          if (port_q) rdata1_d = m_axi_rdata_i;
          else        rdata0_d = m_axi_rdata_i;
          state_d = DONE;
        end
      end
      WRITE: begin
        // AW and W complete independently; leave only when both are done.
        awOk_d = awDone;
        wOk_d  = wDone;
        if (awDone && wDone) state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid_i) begin
          err_d   = |m_axi_bresp_i;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o          = (state_q != IDLE);
  assign done0_o         = (state_q == DONE) && !port_q;
  assign done1_o         = (state_q == DONE) && port_q;
  assign err0_o          = done0_o && err_q;
  assign err1_o          = done1_o && err_q;
  assign rdata0_o        = rdata0_q;
  assign rdata1_o        = rdata1_q;

  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arvalid_o = (state_q == RADDR);
  assign m_axi_rready_o  = (state_q == RDATA);
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awvalid_o = (state_q == WRITE) && !awOk_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wvalid_o  = (state_q == WRITE) && !wOk_q;
  assign m_axi_wlast_o   = 1'b1;
  assign m_axi_bready_o  = (state_q == WRESP);

  // Fixed single-beat 16-byte INCR transactions.
  assign m_axi_arburst_o  = 2'b01;
  assign m_axi_arsize_o   = 3'b100;
  assign m_axi_arlen_o    = 8'd0;
  assign m_axi_arid_o     = 4'd0;
  assign m_axi_arlock_o   = 1'b0;
  assign m_axi_arcache_o  = 4'b0011;
  assign m_axi_arprot_o   = 3'd0;
  assign m_axi_arqos_o    = 4'd0;
  assign m_axi_arregion_o = 4'd0;
  assign m_axi_awburst_o  = 2'b01;
  assign m_axi_awsize_o   = 3'b100;
  assign m_axi_awlen_o    = 8'd0;
  assign m_axi_awid_o     = 4'd0;
  assign m_axi_awlock_o   = 1'b0;
  assign m_axi_awcache_o  = 4'b0011;
  assign m_axi_awprot_o   = 3'd0;
  assign m_axi_awqos_o    = 4'd0;
  assign m_axi_awregion_o = 4'd0;

endmodule

// File: tb/tb_mig_axi_arbiter.sv
// Directed bench for mig_axi_arbiter: AXI slave model with line memory and a
// scoreboard queue of expected completions checked on every done pulse.
module tb_mig_axi_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, we0, req1, we1;
  logic [31:0]  addr0, addr1;
  logic [127:0] wdata0, wdata1;
  logic [15:0]  wstrb0, wstrb1;
  logic         done0, done1, err0, err1, busy;
  logic [127:0] rdata0, rdata1;
  logic [31:0]  araddr, awaddr;
  logic         arvalid, arready, rvalid, rready;
  logic         awvalid, awready, wvalid, wready, bvalid, bready, wlast;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [7:0]   arlen, awlen;
  logic [3:0]   arid, awid, arcache, awcache, arqos, awqos, arregion, awregion;
  logic         arlock, awlock;
  logic [127:0] rdata, wdata;
  logic [15:0]  wstrb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         port;
    logic         we;
    logic [127:0] rdata;
    logic         err;
  } exp_t;
  exp_t expQ[$];

  logic [127:0] slaveMem [256];
  logic [127:0] refMem   [256];
  logic [1:0]   rrespCfg;
  logic         splitMode;
  int           writeCount;
  logic [31:0]  lastAraddr;
  logic [7:0]   lastArlen;
  logic [2:0]   lastArsize;

  always #5 clk = ~clk;

  mig_axi_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .wstrb0_i(wstrb0),
    .done0_o(done0), .rdata0_o(rdata0), .err0_o(err0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .wstrb1_i(wstrb1),
    .done1_o(done1), .rdata1_o(rdata1), .err1_o(err1),
    .busy_o(busy),
    .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_arburst_o(arburst), .m_axi_arsize_o(arsize), .m_axi_arlen_o(arlen),
    .m_axi_arid_o(arid), .m_axi_arlock_o(arlock), .m_axi_arcache_o(arcache),
    .m_axi_arprot_o(arprot), .m_axi_arqos_o(arqos), .m_axi_arregion_o(arregion),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_awburst_o(awburst), .m_axi_awsize_o(awsize), .m_axi_awlen_o(awlen),
    .m_axi_awid_o(awid), .m_axi_awlock_o(awlock), .m_axi_awcache_o(awcache),
    .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos), .m_axi_awregion_o(awregion),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
  );

  function automatic logic [127:0] mergeLine(input logic [127:0] old,
                                             input logic [127:0] data,
                                             input logic [15:0] strb);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Slave model: zero-wait AR/W, optional delayed AWREADY after W handshake.
  logic         awGot, wGot;
  logic [31:0]  awAddrL;
  logic [127:0] wDataL;
  logic [15:0]  wStrbL;
  int           holdCnt;

  assign arready = 1'b1;
  assign wready  = 1'b1;
  assign awready = !splitMode || (wGot && holdCnt == 0);
  assign bresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    logic         aNow, wNow;
    logic [31:0]  aAddr;
    logic [127:0] dNow;
    logic [15:0]  sNow;
    if (rst) begin
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
      awGot   <= 1'b0;
      wGot    <= 1'b0;
      holdCnt <= 0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      if (arvalid && arready) begin
        lastAraddr <= araddr;
        lastArlen  <= arlen;
        lastArsize <= arsize;
        rvalid     <= 1'b1;
        rdata      <= slaveMem[araddr[11:4]];
        rresp      <= rrespCfg;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
      if (holdCnt > 0) holdCnt <= holdCnt - 1;
      aNow  = awGot || (awvalid && awready);
      wNow  = wGot || (wvalid && wready);
      aAddr = awGot ? awAddrL : awaddr;
      dNow  = wGot ? wDataL : wdata;
      sNow  = wGot ? wStrbL : wstrb;
      if (aNow && wNow) begin
        slaveMem[aAddr[11:4]] <= mergeLine(slaveMem[aAddr[11:4]], dNow, sNow);
        writeCount <= writeCount + 1;
        bvalid <= 1'b1;
        awGot  <= 1'b0;
        wGot   <= 1'b0;
      end else begin
        if (awvalid && awready && !awGot) begin
          awGot   <= 1'b1;
          awAddrL <= awaddr;
        end
        if (wvalid && wready && !wGot) begin
          wGot    <= 1'b1;
          wDataL  <= wdata;
          wStrbL  <= wstrb;
          holdCnt <= 3;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done0 || done1) begin
        checkOutput("doneExclusive", done0 & done1, 0);
        total++;
        assert (expQ.size() != 0) else begin
          bad++;
          $error("[TB] FAIL unexpectedDone: observed=done expected=none queued");
        end
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("grantPort", done1, e.port);
          checkOutput("errFlag", done1 ? err1 : err0, e.err);
          if (!e.we) checkOutput("readData", done1 ? rdata1 : rdata0, e.rdata);
        end
      end
      if (err0 || err1)
        checkOutput("errWithoutDone", (err0 & !done0) | (err1 & !done1), 0);
      if (arvalid || awvalid || wvalid) begin
        checkOutput("singleOutstanding", arvalid & (awvalid | wvalid), 0);
        checkOutput("busyWhileValid", busy, 1);
      end
    end
  end

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [127:0] data, input logic [15:0] strb,
                               input logic expErr);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.err   = expErr;
    e.rdata = refMem[addr[11:4]];
    if (we) refMem[addr[11:4]] = mergeLine(refMem[addr[11:4]], data, strb);
    expQ.push_back(e);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; wstrb1 = strb;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; wstrb0 = strb;
    end
  endtask

  task automatic waitDone(input logic port, output int cycles);
    int n;
    n = 0;
    @(negedge clk);
    while ((port ? done1 : done0) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(port ? "done1Seen" : "done0Seen", port ? done1 : done0, 1);
    cycles = n;
    @(posedge clk);
    #1;
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat2, wcBefore;
    logic [127:0] aaLine;
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; wstrb0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; wstrb1 = 0;
    rrespCfg = 2'b00; splitMode = 1'b0; writeCount = 0;
    lastAraddr = 0; lastArlen = 8'hFF; lastArsize = 0;
    for (int i = 0; i < 256; i++) begin
      slaveMem[i] = {4{32'hC0DE_0000 | 32'(i)}};
      refMem[i]   = slaveMem[i];
    end
    #12;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone0", done0, 0);
    checkOutput("rstDone1", done1, 0);
    checkOutput("rstErr", {err1, err0}, 0);
    checkOutput("rstValids", {arvalid, awvalid, wvalid}, 0);
    checkOutput("rstReadies", {rready, bready}, 0);
    checkOutput("rstAraddr", araddr, 0);
    checkOutput("rstAwaddr", awaddr, 0);
    checkOutput("rstWdata", wdata, 0);
    checkOutput("rstWstrb", wstrb, 0);
    checkOutput("rstRdata0", rdata0, 0);
    checkOutput("rstRdata1", rdata1, 0);
    checkOutput("constBurstCache", {arburst, arcache, awburst, awcache}, 12'b01_0011_01_0011);
    checkOutput("constWlastSize", {wlast, awsize, awlen}, {1'b1, 3'b100, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single read, port 0");
    applyStimulus(0, 0, 32'h0000_010C, '0, '0, 0);
    waitDone(0, lat);
    checkOutput("readLatency", lat, 3);
    checkOutput("araddrAligned", lastAraddr, 32'h100);
    checkOutput("arlen", lastArlen, 0);
    checkOutput("arsize", lastArsize, 3'b100);
    checkOutput("done0OneCycle", done0, 0);
    checkOutput("busyIdleAfterRead", busy, 0);

    $display("[TB] strobed write, port 1, then read back");
    applyStimulus(1, 1, 32'h0000_0200, {16{8'hAA}}, 16'h00F0, 0);
    waitDone(1, lat);
    checkOutput("writeLatency", lat, 3);
    checkOutput("done1OneCycle", done1, 0);
    aaLine = slaveMem[8'h20];
    checkOutput("strobeBytes", aaLine,
                {64'hC0DE_0020_C0DE_0020, 32'hAAAA_AAAA, 32'hC0DE_0020});
    applyStimulus(1, 0, 32'h0000_0200, '0, '0, 0);
    waitDone(1, lat);

    $display("[TB] simultaneous requests x4");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 0, 32'h0000_0300 + 32'(r * 16), '0, '0, 0);
      applyStimulus(1, 0, 32'h0000_0400 + 32'(r * 16), '0, '0, 0);
      fork
        waitDone(0, lat);
        waitDone(1, lat2);
      join
    end

    $display("[TB] split write handshake");
    splitMode = 1'b1;
    wcBefore = writeCount;
    applyStimulus(1, 1, 32'h0000_0500, {4{32'h1234_5678}}, 16'hFFFF, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("splitWvalidDropped", wvalid, 0);
    checkOutput("splitAwvalidHeld", awvalid, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("splitAwvalidStillHeld", awvalid, 1);
    checkOutput("splitNoEarlyWresp", bready, 0);
    waitDone(1, lat);
    checkOutput("splitWriteCount", writeCount - wcBefore, 1);
    splitMode = 1'b0;
    applyStimulus(0, 0, 32'h0000_0500, '0, '0, 0);
    waitDone(0, lat);

    $display("[TB] error response");
    rrespCfg = 2'b10;
    applyStimulus(0, 0, 32'h0000_0700, '0, '0, 1);
    waitDone(0, lat);
    checkOutput("busyIdleAfterErr", busy, 0);
    rrespCfg = 2'b00;

    $display("[TB] async reset in RDATA");
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0600;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("rreadyBeforeReset", rready, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidRready", rready, 0);
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidDone0", done0, 0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idleAfterReset", busy, 0);
    applyStimulus(0, 0, 32'h0000_0600, '0, '0, 0);
    waitDone(0, lat);
    checkOutput("readLatencyAfterReset", lat, 3);

    repeat (3) @(posedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
